icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. Returns hits combinationally so the fetch stage advances every cycle on a hit. On a miss, it fetches exactly one word through a two-state FSM, fills the frame, and hits on the following cycle.

## Interface
Parameters:
- `SETS`, 16, number of frames; power of two, at least 2.
- `IDX_W`, `$clog2(SETS)` (4), index width.
- `TAG_W`, `30 - IDX_W` (26), tag width.

Ports:
- `CLK` in 1: single clock; all state updates on posedge.
- `nRST` in 1: reset, synchronous and active-low.
- `imemREN` in 1: datapath requests an instruction.
- `imemaddr` in 32: fetch address; bits [1:0] ignored.
- `ihit` out 1: `imemload` is valid this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: read request to the memory controller.
- `iaddr` out 32: word-aligned address to the memory controller.
- `iwait` in 1: memory controller is busy; low means `iload` is valid.
- `iload` in 32: word returned by the memory controller.
- `hit_count` out 16: saturating count of hits.
- `miss_count` out 16: saturating count of misses.

## Operation
- Address split:
  - tag = `imemaddr[31:IDX_W+2]`
  - index = `imemaddr[IDX_W+1:2]`
  - offset [1:0] ignored.
- Each frame holds `valid`, `tag[TAG_W-1:0]` and `data[31:0]`.
- Hit is defined as `imemREN & state==IDLE & frame[index].valid & frame[index].tag==tag`.
- Output behaviour:
  - `ihit` equals the hit term.
  - `imemload` equals `frame[index].data` when `ihit` is high, otherwise 0.
- FSM states: `IDLE`, `FETCH`.
- `IDLE`:
  - `iREN` = 0.
  - On `imemREN & ~hit`: latch `miss_addr <= {imemaddr[31:2],2'b00}`, increment `miss_count`, go to `FETCH`.
  - On a hit: increment `hit_count`, stay in `IDLE`.
  - With `imemREN` low: do nothing.
- `FETCH`:
  - `iREN` = 1, `iaddr` = `miss_addr`, `ihit` = 0.
  - When `iwait` = 0, write `frame[miss_addr index] <= {1, miss_addr tag, iload}` and go to `IDLE`.
- `iaddr` equals `miss_addr` in every state; it is meaningful only while `iREN` is high.
- A fill, once started, always completes:
  - `imemREN` dropping, or `imemaddr` changing during `FETCH`, does not abort it.
  - The fill uses the latched `miss_addr`.
- Replacement: a fill unconditionally overwrites the indexed frame.
- Counters saturate at 16'hFFFF; neither counter wraps.

## Timing
- Reset: when `nRST` is low at a posedge, the following take effect at that edge:
  - All `valid` bits cleared.
  - State = `IDLE`; `miss_addr` = 0; both counters = 0.
  - Tag and data contents need not be reset.
- Output values while reset is held low:
  - `iREN` = 0
  - `iaddr` = 0
  - `ihit` = 0
  - `imemload` = 0
- Reset asserted during `FETCH`: the fill is dropped and nothing is written. The memory controller sees `iREN` fall on the next cycle.
- Hit latency: 0 cycles (combinational from `imemaddr`).
- Miss timing:
  - Cycle 0: miss detected.
  - Cycles 1..N: `FETCH`, ending with the cycle in which `iwait` = 0.
  - Cycle N+1: `IDLE` and hit.
  - Minimum miss penalty is therefore 2 cycles.
- No request is issued back-to-back: after a fill, `iREN` is low for at least the one `IDLE` cycle.
- A fill and a read of the same index never coincide, because `ihit` is forced to 0 in `FETCH`.

## Structure
- Add to `cpu_types_pkg`:
  - `icache_frame_t`, a packed struct of valid, tag and data.
  - `icache_state_t`, an enum of `IDLE` and `FETCH`.
  - `ICACHE_SETS`, a localparam set to 16.
- No sub-module:
  - The frame array, FSM and two counters sit in one module.
  - The saturating counter is inlined twice.
- The datapath-side ports map one-to-one onto the fetch signals of the datapath/cache interface. The memory-side ports map onto the instruction side of the cache/memory-controller interface.

## Test plan
- **Cold miss then hit.** After reset, `imemREN` = 1 and `imemaddr` = 0x0000_0040; `iwait` is high for 3 cycles, then low with `iload` = 0x2001_0005.
  - `iREN` is high for 4 cycles with `iaddr` = 0x40.
  - On the next cycle `ihit` = 1 and `imemload` = 0x2001_0005.
  - Counters read `miss_count` = 1, `hit_count` = 1.
- **Conflict eviction.** Fill 0x0000_0000, then access 0x0000_0040 (same index 0, different tag).
  - The second access misses and refills.
  - Re-accessing 0x0 misses again.
- **Address change mid-fill.** Miss on 0x80, then change `imemaddr` to 0x100 during `FETCH`.
  - `iaddr` stays 0x80 and the frame for 0x80 is filled.
  - The next cycle misses on 0x100.
- **Reset mid-fill.** Pull `nRST` low during `FETCH`.
  - `iREN` = 0 after the edge and all frames are invalid.
  - A re-access to the same address misses.
- **Saturation and idle.** Force `hit_count` up to 0xFFFF with repeated hits.
  - `hit_count` stays at 0xFFFF.
  - With `imemREN` = 0, neither counter changes and `iREN` stays 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache frame layout, cache FSM states and cache geometry.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, single-word fill on a miss,
// saturating hit/miss counters.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    icache_frame_t    frames [SETS];
    icache_state_t    state, state_n;
    logic [31:0]      miss_addr;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic             hit, fill;
    logic             unused_offset;

    assign req_tag  = imemaddr[31:IDX_W+2];
    assign req_idx  = imemaddr[IDX_W+1:2];
    assign fill_tag = miss_addr[31:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign unused_offset = ^{imemaddr[1:0], miss_addr[1:0]};

    // Hits are only possible in IDLE, so a fill never races a read of the same frame.
    always_comb begin
        state_n = state;
        hit     = 1'b0;
        fill    = 1'b0;
        iREN    = 1'b0;
        unique case (state)
            IDLE: begin
                hit = imemREN && frames[req_idx].valid && (frames[req_idx].tag == req_tag);
                if (imemREN && !hit) state_n = FETCH;
            end
            FETCH: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    assign ihit     = hit;
    assign imemload = hit ? frames[req_idx].data : 32'h0;
    assign iaddr    = miss_addr;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            miss_addr  <= 32'h0;
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
            for (int i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && imemREN && !hit) begin
                miss_addr <= {imemaddr[31:2], 2'b00};
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            if (fill) frames[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected hit data and expected memory requests are queued by the
// stimulus thread and retired by a negedge monitor.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    logic [31:0] hit_q[$];
    logic [31:0] req_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          ren_cycles = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: retires expected hit words and memory request addresses.
    always @(negedge CLK) begin
        if (ihit === 1'b1) begin
            if (hit_q.size() == 0) check("unexpected_hit", {31'b0, ihit}, 32'h0);
            else check("hit_data", imemload, hit_q.pop_front());
        end else if (imemload !== 32'h0) begin
            check("load_zero_on_miss", imemload, 32'h0);
        end
        if (iREN === 1'b1) begin
            ren_cycles++;
            if (iwait === 1'b0) begin
                if (req_q.size() == 0) check("unexpected_req", iaddr, 32'hFFFF_FFFF);
                else check("req_addr", iaddr, req_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic hit_cycle(input logic [31:0] addr, input logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        hit_q.push_back(data);
        step();
    endtask

    // Issues a missing access and serves the fill after `lat` busy cycles; returns in the IDLE
    // cycle that follows the fill.
    task automatic miss_fill(input logic [31:0] addr, input int lat, input logic [31:0] data);
        imemREN  = 1'b1;
        imemaddr = addr;
        req_q.push_back({addr[31:2], 2'b00});
        step();
        for (int k = 0; k < lat; k++) begin
            iwait = 1'b1;
            step();
        end
        iwait = 1'b0;
        iload = data;
        step();
        iwait = 1'b1;
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        step();
        step();
        check("rst_iREN", {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        check("rst_hit_count", {16'b0, hit_count}, 32'h0);
        check("rst_miss_count", {16'b0, miss_count}, 32'h0);
        nRST = 1'b1;
        step();

        // Cold miss then hit
        ren_cycles = 0;
        miss_fill(32'h0000_0040, 3, 32'h2001_0005);
        check("cold_ren_cycles", ren_cycles, 4);
        check("post_fill_iREN", {31'b0, iREN}, 32'h0);
        hit_cycle(32'h0000_0040, 32'h2001_0005);
        check("cold_miss_count", {16'b0, miss_count}, 32'd1);
        check("cold_hit_count", {16'b0, hit_count}, 32'd1);

        // Conflict eviction on index 0
        miss_fill(32'h0000_0000, 0, 32'h1111_1111);
        hit_cycle(32'h0000_0000, 32'h1111_1111);
        miss_fill(32'h0000_0040, 1, 32'h2222_2222);
        hit_cycle(32'h0000_0040, 32'h2222_2222);
        miss_fill(32'h0000_0000, 0, 32'h3333_3333);
        hit_cycle(32'h0000_0000, 32'h3333_3333);
        check("conflict_miss_count", {16'b0, miss_count}, 32'd4);
        check("conflict_hit_count", {16'b0, hit_count}, 32'd4);

        // Address change and request drop mid-fill
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        req_q.push_back(32'h0000_0080);
        step();
        imemaddr = 32'h0000_0100;
        imemREN  = 1'b0;
        iwait    = 1'b1;
        step();
        check("midfill_iaddr", iaddr, 32'h0000_0080);
        imemREN = 1'b1;
        iwait   = 1'b0;
        iload   = 32'h4444_4444;
        step();
        iwait = 1'b1;
        check("midfill_next_ihit", {31'b0, ihit}, 32'h0);
        check("midfill_miss_count", {16'b0, miss_count}, 32'd5);
        req_q.push_back(32'h0000_0100);
        step();
        iwait = 1'b0;
        iload = 32'h5555_5555;
        step();
        iwait = 1'b1;
        hit_cycle(32'h0000_0100, 32'h5555_5555);
        check("midfill_miss_count2", {16'b0, miss_count}, 32'd6);

        // Reset mid-fill
        imemaddr = 32'h0000_0200;
        step();
        check("rstfill_iREN_before", {31'b0, iREN}, 32'h1);
        nRST = 1'b0;
        step();
        check("rstfill_iREN_after", {31'b0, iREN}, 32'h0);
        check("rstfill_iaddr", iaddr, 32'h0);
        check("rstfill_miss_count", {16'b0, miss_count}, 32'h0);
        nRST     = 1'b1;
        imemaddr = 32'h0000_0100;
        #1;
        check("rstfill_invalid", {31'b0, ihit}, 32'h0);
        miss_fill(32'h0000_0100, 0, 32'h7777_7777);
        hit_cycle(32'h0000_0100, 32'h7777_7777);
        miss_fill(32'h0000_0200, 0, 32'h6666_6666);
        hit_cycle(32'h0000_0200, 32'h6666_6666);
        check("rstfill_counts", {hit_count, miss_count}, {16'd2, 16'd2});

        // Saturation: 65540 more hits pushes hit_count past its ceiling
        for (int i = 0; i < 65540; i++) hit_cycle(32'h0000_0200, 32'h6666_6666);
        check("sat_hit_count", {16'b0, hit_count}, 32'h0000_FFFF);
        check("sat_miss_count", {16'b0, miss_count}, 32'd2);

        // Idle: nothing moves
        imemREN    = 1'b0;
        ren_cycles = 0;
        for (int i = 0; i < 5; i++) step();
        check("idle_counts", {hit_count, miss_count}, {16'hFFFF, 16'd2});
        check("idle_ren_cycles", ren_cycles, 0);
        check("idle_ihit", {31'b0, ihit}, 32'h0);

        check("hit_q_drained", hit_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
